muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 126 ++++++++++++
 tb/tb_muldiv_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per clock,
// WIDTH iterations, signed operands handled as magnitudes with sign fix on the last edge.
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             neg_lo;
  logic             neg_hi;

  // Operand conditioning for the accepting edge; op[0] selects signed forms.
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  assign sa       = op[0] & a[WIDTH-1];
  assign sb       = op[0] & b[WIDTH-1];
  assign mag_a_in = sa ? -a : a;
  assign mag_b_in = sb ? -b : b;

  // Multiply step: add multiplicand when the multiplier LSB is set, then shift right.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

  // Divide step: shift next dividend bit into the remainder and try to subtract.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b};
  assign div_ge    = div_shift >= {1'b0, mag_b};
  assign div_hi_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo_n  = {acc_lo[WIDTH-2:0], div_ge};

  logic [WIDTH-1:0]   hi_n, lo_n;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   fin_lo, fin_hi;
  assign hi_n     = is_div ? div_hi_n : mul_hi_n;
  assign lo_n     = is_div ? div_lo_n : mul_lo_n;
  assign prod     = {mul_hi_n, mul_lo_n};
  assign prod_fix = neg_lo ? -prod : prod;
  assign fin_lo   = is_div ? (neg_lo ? -div_lo_n : div_lo_n) : prod_fix[WIDTH-1:0];
  assign fin_hi   = is_div ? (neg_hi ? -div_hi_n : div_hi_n) : prod_fix[2*WIDTH-1:WIDTH];

  // NOTE: every register here is updated with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      mag_b  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      res_lo <= '0;
      res_hi <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (start && !(kill && state == DONE)) begin
            state  <= RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= op[1];
            mag_b  <= mag_b_in;
            acc_hi <= '0;
            acc_lo <= mag_a_in;
            // A zero divisor keeps the quotient at all ones; the remainder follows the dividend.
            neg_lo <= (sa ^ sb) & (op[1] ? (b != '0) : 1'b1);
            neg_hi <= op[1] ? sa : (sa ^ sb);
          end
        end
        RUN: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            acc_hi <= hi_n;
            acc_lo <= lo_n;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              cnt    <= '0;
              res_lo <= fin_lo;
              res_hi <= fin_hi;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic results, latency,
// start/kill/reset behaviour during RUN, and back-to-back issue from DONE.
module tb_muldiv_unit;

  localparam logic [1:0] MULU = 2'b00, MULS = 2'b01, DIVU = 2'b10, DIVS = 2'b11;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] res_lo, res_hi;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .kill(kill),
    .busy(busy), .done(done), .res_lo(res_lo), .res_hi(res_hi)
  );

  always #5 clk = ~clk;

  // Called at a negedge; the next posedge is the accepting edge E0. Returns at the following negedge.
  task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'bxx; a = 'x; b = 'x;
  endtask

  // Waits for done; lat is the number of posedges including E0 (edges_so_far already elapsed).
  task automatic wait_done(input int edges_so_far, output int lat, output int bcnt,
                           output logic [15:0] lo, output logic [15:0] hi);
    int e;
    e = edges_so_far; lat = -1; bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e++;
      if (done) begin lat = e; break; end
      if (busy) bcnt++;
    end
    lo = res_lo; hi = res_hi;
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] exp_lo, input logic [15:0] exp_hi);
    int lat, bc;
    logic [15:0] lo, hi;
    issue(o, x, y);
    wait_done(1, lat, bc, lo, hi);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL %s_latency got %0d exp 17", name, lat); end
    n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL %s_lo got %h exp %h", name, lo, exp_lo); end
    n_checks++; if (hi !== exp_hi) begin n_fail++; $display("FAIL %s_hi got %h exp %h", name, hi, exp_hi); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = MULU; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_checks++; if ({busy, done, res_lo, res_hi} !== 34'h0) begin
      n_fail++; $display("FAIL reset_outputs got %h exp 0", {busy, done, res_lo, res_hi}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mulu();
    int lat, bc;
    logic [15:0] lo, hi;
    issue(MULU, 16'hFFFF, 16'hFFFF);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mulu_busy_after_e0 got %b exp 1", busy); end
    wait_done(1, lat, bc, lo, hi);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL mulu_latency got %0d exp 17", lat); end
    n_checks++; if (bc + 1 !== 16) begin n_fail++; $display("FAIL mulu_busy_cycles got %0d exp 16", bc + 1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mulu_busy_in_done got %b exp 0", busy); end
    n_checks++; if (lo !== 16'h0001) begin n_fail++; $display("FAIL mulu_lo got %h exp 0001", lo); end
    n_checks++; if (hi !== 16'hFFFE) begin n_fail++; $display("FAIL mulu_hi got %h exp fffe", hi); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mulu_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_muls();
    run_op("muls_neg", MULS, 16'hFFFE, 16'h0003, 16'hFFFA, 16'hFFFF);
    run_op("muls_min", MULS, 16'h8000, 16'h8000, 16'h0000, 16'h4000);
  endtask

  task automatic test_div();
    run_op("divu", DIVU, 16'd100, 16'd7, 16'h000E, 16'h0002);
    run_op("divs_neg", DIVS, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF);
    run_op("divs_ovf", DIVS, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000);
  endtask

  task automatic test_div_zero();
    run_op("divu_zero", DIVU, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234);
    run_op("divs_zero", DIVS, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234);
    run_op("divs_zero_neg", DIVS, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9);
  endtask

  task automatic test_start_in_run();
    int lat, bc;
    logic [15:0] lo, hi;
    issue(DIVU, 16'd100, 16'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; op = MULU; a = 16'd2; b = 16'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(7, lat, bc, lo, hi);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL ignore_start_latency got %0d exp 17", lat); end
    n_checks++; if ({hi, lo} !== 32'h0002_000E) begin
      n_fail++; $display("FAIL ignore_start_result got %h exp 0002000e", {hi, lo}); end
    @(negedge clk);
  endtask

  task automatic test_kill();
    int seen;
    issue(MULU, 16'hFFFF, 16'hFFFF);
    repeat (8) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL kill_busy_done got %b exp 00", {busy, done}); end
    seen = 0;
    repeat (20) begin @(negedge clk); if (done || busy) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL kill_no_done got %0d active cycles exp 0", seen); end
    n_checks++; if ({res_hi, res_lo} !== 32'h0002_000E) begin
      n_fail++; $display("FAIL kill_hold_result got %h exp 0002000e", {res_hi, res_lo}); end
  endtask

  task automatic test_async_reset();
    int seen;
    issue(MULU, 16'h0003, 16'h0005);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({busy, done, res_lo, res_hi} !== 34'h0) begin
      n_fail++; $display("FAIL async_reset got %h exp 0", {busy, done, res_lo, res_hi}); end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin @(negedge clk); if (done) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL reset_no_done got %0d exp 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, pulses;
    logic [15:0] lo, hi;
    issue(MULU, 16'd2, 16'd7);
    wait_done(1, lat, bc, lo, hi);
    n_checks++; if ({hi, lo} !== 32'h0000_000E) begin
      n_fail++; $display("FAIL b2b_first got %h exp 0000000e", {hi, lo}); end
    start = 1'b1; op = MULU; a = 16'd3; b = 16'd5;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL b2b_busy_reassert got %b exp 10", {busy, done}); end
    wait_done(1, lat, bc, lo, hi);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL b2b_latency got %0d exp 17", lat); end
    n_checks++; if ({hi, lo} !== 32'h0000_000F) begin
      n_fail++; $display("FAIL b2b_second got %h exp 0000000f", {hi, lo}); end
    pulses = 0;
    repeat (20) begin @(negedge clk); if (done) pulses++; end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL b2b_extra_done got %0d exp 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_mulu();
    test_muls();
    test_div();
    test_div_zero();
    test_start_in_run();
    test_kill();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
